gb_frame_scaler: RTL and testbench



---
 rtl/gb_frame_scaler.sv | 166 ++++++++++++++++
 tb/tb_gb_frame_scaler.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_frame_scaler.sv
// Scales the 160x144 Game Boy frame buffer 3x into a centred window of the 640x480 raster.
// Optional build macro SCANLINES_EN halves the palette colour on the third line of each source row.
module gb_frame_scaler #(
    parameter int unsigned X0     = 80,
    parameter int unsigned Y0     = 24,
    parameter int unsigned FB_LAT = 1,
    parameter logic [11:0] PAL0   = 12'hEFD,
    parameter logic [11:0] PAL1   = 12'hAC8,
    parameter logic [11:0] PAL2   = 12'h564,
    parameter logic [11:0] PAL3   = 12'h132,
    parameter logic [11:0] BORDER = 12'h000
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic [9:0]  drawX,
    input  logic [9:0]  drawY,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic        active_nblank_in,
    input  logic        frame_ready,
    output logic        fb_rd_en,
    output logic [14:0] fb_rd_addr,
    input  logic [1:0]  fb_rd_data,
    output logic        buf_sel,
    output logic [3:0]  red,
    output logic [3:0]  green,
    output logic [3:0]  blue,
    output logic        hs_out,
    output logic        vs_out,
    output logic        active_nblank_out
);

    localparam int unsigned DlyLen = FB_LAT + 1;
    localparam logic [9:0] XStart = 10'(X0);
    localparam logic [9:0] XLast  = 10'(X0 + 479);
    localparam logic [9:0] XEnd   = 10'(X0 + 480);
    localparam logic [9:0] YStart = 10'(Y0);
    localparam logic [9:0] YEnd   = 10'(Y0 + 432);
    localparam logic [9:0] SwapY  = 10'd480;

    logic        in_win;
    logic [1:0]  col_sub_q, col_sub_cur, row_sub_q;
    logic [7:0]  col_q, col_cur;
    logic [14:0] row_base_q, addr_cur;
    logic        pending_q, swap_pt;

    // Flag delay lines; the top entry lines up with fb_rd_data.
    logic [DlyLen-1:0] hs_p, vs_p, act_p, win_p;
`ifdef SCANLINES_EN
    logic [DlyLen-1:0] scan_p;
`endif
    logic [11:0] pal_rgb, rgb_d;

    assign in_win  = (drawX >= XStart) && (drawX < XEnd) && (drawY >= YStart) && (drawY < YEnd);
    assign swap_pt = (drawY == SwapY) && (drawX == 10'd0);

    // The first window column starts the column counters from zero in the same cycle.
    always_comb begin
        if (drawX == XStart) begin
            col_sub_cur = 2'd0;
            col_cur     = 8'd0;
        end else begin
            col_sub_cur = col_sub_q;
            col_cur     = col_q;
        end
        addr_cur = row_base_q + 15'(col_cur);
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= 15'd0;
            col_sub_q  <= 2'd0;
            col_q      <= 8'd0;
            row_sub_q  <= 2'd0;
            row_base_q <= 15'd0;
        end else begin
            fb_rd_en <= in_win;
            if (in_win) begin
                fb_rd_addr <= addr_cur;
                if (col_sub_cur == 2'd2) begin
                    col_sub_q <= 2'd0;
                    col_q     <= col_cur + 8'd1;
                end else begin
                    col_sub_q <= col_sub_cur + 2'd1;
                    col_q     <= col_cur;
                end
            end
            if (drawY == YStart && drawX == 10'd0) begin
                row_sub_q  <= 2'd0;
                row_base_q <= 15'd0;
            end else if (in_win && drawX == XLast) begin
                if (row_sub_q == 2'd2) begin
                    row_sub_q  <= 2'd0;
                    row_base_q <= row_base_q + 15'd160;
                end else begin
                    row_sub_q <= row_sub_q + 2'd1;
                end
            end
        end
    end

    // A frame completed exactly on the swap cycle stays queued behind the one being swapped in.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            buf_sel   <= 1'b0;
            pending_q <= 1'b0;
        end else if (swap_pt) begin
            if (pending_q || frame_ready) buf_sel <= ~buf_sel;
            pending_q <= pending_q & frame_ready;
        end else if (frame_ready) begin
            pending_q <= 1'b1;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            hs_p   <= '0;
            vs_p   <= '0;
            act_p  <= '0;
            win_p  <= '0;
`ifdef SCANLINES_EN
            scan_p <= '0;
`endif
        end else begin
            hs_p   <= {hs_p[DlyLen-2:0], hs_in};
            vs_p   <= {vs_p[DlyLen-2:0], vs_in};
            act_p  <= {act_p[DlyLen-2:0], active_nblank_in};
            win_p  <= {win_p[DlyLen-2:0], in_win};
`ifdef SCANLINES_EN
            scan_p <= {scan_p[DlyLen-2:0], in_win && (row_sub_q == 2'd2)};
`endif
        end
    end

    always_comb begin
        case (fb_rd_data)
            2'd0:    pal_rgb = PAL0;
            2'd1:    pal_rgb = PAL1;
            2'd2:    pal_rgb = PAL2;
            default: pal_rgb = PAL3;
        endcase
`ifdef SCANLINES_EN
        if (scan_p[DlyLen-1]) begin
            pal_rgb = {1'b0, pal_rgb[11:9], 1'b0, pal_rgb[7:5], 1'b0, pal_rgb[3:1]};
        end
`endif
        rgb_d = 12'h000;
        if (act_p[DlyLen-1]) rgb_d = win_p[DlyLen-1] ? pal_rgb : BORDER;
    end

    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            {red, green, blue} <= 12'h000;
            hs_out             <= 1'b0;
            vs_out             <= 1'b0;
            active_nblank_out  <= 1'b0;
        end else begin
            {red, green, blue} <= rgb_d;
            hs_out             <= hs_p[DlyLen-1];
            vs_out             <= vs_p[DlyLen-1];
            active_nblank_out  <= act_p[DlyLen-1];
        end
    end

endmodule

// File: tb/tb_gb_frame_scaler.sv
// Randomised scoreboard bench for gb_frame_scaler: compressed frames, full sweeps on chosen lines.
module tb_gb_frame_scaler;
    localparam int X0     = 80;
    localparam int Y0     = 24;
    localparam int FB_LAT = 1;
    localparam logic [11:0] BORDER = 12'h000;

    logic        pixel_clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  drawX = '0;
    logic [9:0]  drawY = '0;
    logic        hs_in = 1'b1;
    logic        vs_in = 1'b1;
    logic        active_nblank_in = 1'b0;
    logic        frame_ready = 1'b0;
    logic        fb_rd_en;
    logic [14:0] fb_rd_addr;
    logic [1:0]  fb_rd_data;
    logic        buf_sel;
    logic [3:0]  red, green, blue;
    logic        hs_out, vs_out, active_nblank_out;

    always #5 pixel_clk = ~pixel_clk;

    gb_frame_scaler #(.X0(X0), .Y0(Y0), .FB_LAT(FB_LAT)) dut (
        .pixel_clk        (pixel_clk),
        .reset            (reset),
        .drawX            (drawX),
        .drawY            (drawY),
        .hs_in            (hs_in),
        .vs_in            (vs_in),
        .active_nblank_in (active_nblank_in),
        .frame_ready      (frame_ready),
        .fb_rd_en         (fb_rd_en),
        .fb_rd_addr       (fb_rd_addr),
        .fb_rd_data       (fb_rd_data),
        .buf_sel          (buf_sel),
        .red              (red),
        .green            (green),
        .blue             (blue),
        .hs_out           (hs_out),
        .vs_out           (vs_out),
        .active_nblank_out(active_nblank_out)
    );

    function automatic logic [1:0] shade_of(input logic [14:0] a);
        logic [14:0] h;
        h = a ^ (a >> 3) ^ (a >> 7);
        return h[1:0];
    endfunction

    function automatic logic [11:0] pal(input logic [1:0] s);
        case (s)
            2'd0:    return 12'hEFD;
            2'd1:    return 12'hAC8;
            2'd2:    return 12'h564;
            default: return 12'h132;
        endcase
    endfunction

    function automatic logic [11:0] half(input logic [11:0] c);
        return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
    endfunction

    // Frame buffer memory: fixed content per address, FB_LAT-clock read pipe.
    logic [1:0] fb_sr [FB_LAT] = '{default: 2'b00};
    always @(posedge pixel_clk) begin
        fb_sr[0] <= shade_of(fb_rd_addr);
        for (int i = 1; i < FB_LAT; i++) fb_sr[i] <= fb_sr[i-1];
    end
    assign fb_rd_data = fb_sr[FB_LAT-1];

    typedef struct {
        int          due;
        logic        en;
        logic        addr_k;
        logic [14:0] addr;
        logic        bsel;
    } fb_exp_t;

    typedef struct {
        int          due;
        logic        hs;
        logic        vs;
        logic        act;
        logic        rgb_k;
        logic [11:0] rgb;
    } px_exp_t;

    fb_exp_t fbq[$];
    px_exp_t pxq[$];
    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge pixel_clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, x=%0d y=%0d)",
                     name, got, want, cyc, drawX, drawY);
        end
    endtask

    // Monitor: pops expectations whose due cycle has arrived.
    fb_exp_t mfe;
    px_exp_t mpe;
    always @(negedge pixel_clk) begin
        while (fbq.size() > 0 && fbq[0].due <= cyc) begin
            mfe = fbq.pop_front();
            chk("fb_due", 32'(mfe.due), 32'(cyc));
            chk("fb_rd_en", {31'b0, fb_rd_en}, {31'b0, mfe.en});
            chk("buf_sel", {31'b0, buf_sel}, {31'b0, mfe.bsel});
            if (mfe.addr_k) chk("fb_rd_addr", {17'b0, fb_rd_addr}, {17'b0, mfe.addr});
        end
        while (pxq.size() > 0 && pxq[0].due <= cyc) begin
            mpe = pxq.pop_front();
            chk("px_due", 32'(mpe.due), 32'(cyc));
            chk("hs_out", {31'b0, hs_out}, {31'b0, mpe.hs});
            chk("vs_out", {31'b0, vs_out}, {31'b0, mpe.vs});
            chk("active_nblank_out", {31'b0, active_nblank_out}, {31'b0, mpe.act});
            if (mpe.rgb_k) chk("rgb", {20'b0, red, green, blue}, {20'b0, mpe.rgb});
        end
    end

    // Reference model state.
    int m_prev_x = -1, m_prev_y = -1, m_adv = 0, m_eaddr = 0;
    bit m_frame_ok = 0, m_line_ok = 0, m_pending = 0, m_bsel = 0, m_addr_k = 1, m_rel = 0;

    task automatic push_zero_px(input int due);
        px_exp_t pe;
        pe.due = due; pe.hs = 0; pe.vs = 0; pe.act = 0; pe.rgb_k = 1; pe.rgb = 12'h000;
        pxq.push_back(pe);
    endtask

    task automatic step(input int x, input int y, input bit fr, input bit rst);
        fb_exp_t fe;
        px_exp_t pe;
        bit win, act, valid;
        logic [11:0] c;
        reset = rst;
        drawX = 10'(x);
        drawY = 10'(y);
        frame_ready = fr;
        hs_in = 1'($urandom);
        vs_in = 1'($urandom);
        act = (x < 640) && (y < 480);
        active_nblank_in = act;
        win = (x >= X0) && (x < X0 + 480) && (y >= Y0) && (y < Y0 + 432);
        if (rst) begin
            // Reset overtakes anything still in flight.
            while (fbq.size() > 0 && fbq[fbq.size()-1].due > cyc) fbq.delete(fbq.size()-1);
            while (pxq.size() > 0 && pxq[pxq.size()-1].due > cyc) pxq.delete(pxq.size()-1);
            fe.due = cyc + 1; fe.en = 0; fe.addr_k = 1; fe.addr = 15'd0; fe.bsel = 0;
            fbq.push_back(fe);
            push_zero_px(cyc + 1);
            m_frame_ok = 0; m_line_ok = 0; m_pending = 0; m_bsel = 0;
            m_addr_k = 1; m_eaddr = 0; m_rel = 1; m_prev_x = -1; m_prev_y = -1;
        end else begin
            if (m_rel) begin
                for (int d = 1; d <= FB_LAT + 1; d++) push_zero_px(cyc + d);
                m_rel = 0;
            end
            if (y != m_prev_y) m_line_ok = 0;
            if (y == Y0 && x == 0) begin
                m_frame_ok = 1;
                m_adv = 0;
            end
            if (win) begin
                if (x == X0) m_line_ok = 1;
                else if (x != m_prev_x + 1) m_line_ok = 0;
            end
            valid = m_frame_ok && m_line_ok && (m_adv == y - Y0);
            if (win) begin
                m_addr_k = valid;
                if (valid) m_eaddr = ((y - Y0) / 3) * 160 + (x - X0) / 3;
            end
            if (y == 480 && x == 0) begin
                if (m_pending || fr) m_bsel = !m_bsel;
                m_pending = m_pending & fr;
            end else if (fr) begin
                m_pending = 1;
            end
            fe.due = cyc + 1; fe.en = win; fe.addr_k = m_addr_k;
            fe.addr = 15'(m_eaddr); fe.bsel = m_bsel;
            fbq.push_back(fe);
            pe.due = cyc + FB_LAT + 2; pe.hs = hs_in; pe.vs = vs_in; pe.act = act;
            pe.rgb_k = 1;
            if (!act) begin
                pe.rgb = 12'h000;
            end else if (!win) begin
                pe.rgb = BORDER;
            end else if (valid) begin
                c = pal(shade_of(15'(m_eaddr)));
`ifdef SCANLINES_EN
                if ((y - Y0) % 3 == 2) c = half(c);
`endif
                pe.rgb = c;
            end else begin
                pe.rgb_k = 0;
                pe.rgb = 12'h000;
            end
            pxq.push_back(pe);
            if (win && x == X0 + 479) m_adv++;
            m_prev_x = x;
            m_prev_y = y;
        end
        @(posedge pixel_clk);
        #1;
    endtask

    int full_lines[$];
    int fr_a, fr_b, rst_line, rst_x;

    function automatic bit is_full(input int y);
        foreach (full_lines[i]) if (full_lines[i] == y) return 1;
        return 0;
    endfunction

    // One frame: every line visits x=0; chosen lines are swept across the whole window,
    // other window lines only touch their last window column.
    task automatic run_frame();
        for (int y = 0; y < 525; y++) begin
            step(0, y, (y == fr_a) || (y == fr_b), 0);
            if (is_full(y)) begin
                for (int x = X0 - 4; x <= X0 + 483; x++)
                    step(x, y, 0, (y == rst_line) && (x >= rst_x) && (x < rst_x + 3));
            end else if (y >= Y0 && y < Y0 + 432) begin
                if ($urandom_range(0, 1) == 0) step($urandom_range(1, X0 - 1), y, 0, 0);
                else step($urandom_range(X0 + 480, 799), y, 0, 0);
                step(X0 + 479, y, 0, 0);
            end else begin
                step($urandom_range(1, 799), y, 0, 0);
            end
        end
    endtask

    initial begin
        rst_line = -1;
        rst_x = 0;
        for (int i = 0; i < 3; i++) step($urandom_range(0, 799), $urandom_range(0, 524), 0, 1);

        // Two completed frames before the swap point give a single toggle.
        full_lines = '{24, 25, 26, 27, 455};
        full_lines.push_back($urandom_range(28, 454));
        fr_a = 100; fr_b = 200;
        run_frame();

        // A frame completing on the swap cycle stays queued for the next frame.
        full_lines = '{24, 455};
        full_lines.push_back($urandom_range(25, 454));
        fr_a = 300; fr_b = 480;
        run_frame();

        fr_a = -1; fr_b = -1;
        full_lines = '{24, 455};
        run_frame();

        // Reset mid-line clears the pending frame as well.
        full_lines = '{24, 30};
        fr_a = 10; fr_b = -1;
        rst_line = 30; rst_x = 200;
        run_frame();

        rst_line = -1;
        full_lines = '{24, 26, 455};
        full_lines.push_back($urandom_range(27, 454));
        fr_a = $urandom_range(1, 479); fr_b = -1;
        run_frame();

        repeat (FB_LAT + 4) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checks++;
        if (fbq.size() != 0 || pxq.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d/%0d outstanding expected 0/0", fbq.size(), pxq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
